sha3_arbiter: RTL
=================

SHA3_ARBITER -- requirements
Module: sha3_arbiter

Interface
REQ-001 The block SHALL provide these ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  per-requester service request, level; bit0 = matrix generator, bit1 = noise sampler.
- req_mode  in  2  per-requester SHAKE select; 0 = SHAKE128, 1 = SHAKE256.
- req_absorb_num0, req_absorb_num1  in  8 each  absorb block count per requester.
- req_last_bytes0, req_last_bytes1  in  8 each  last-block byte count per requester.
- req_blocks0, req_blocks1  in  16 each  output blocks to dump per requester.
- gnt  out  2  one-hot grant; held for the whole transaction.
- done  out  2  one-cycle completion pulse, on the granted bit.
- blk_valid  out  1  one-cycle pulse when a dumped block has been written.
- blk_idx  out  16  index of the block flagged by blk_valid, starting at 0.
- sha3_start, sha3_squeezeonce, sha3_dumponce  out  1 each  command pulses to the SHA3 controller.
- shakemode  out  1  mode to the SHA3 controller.
- absorb_num, last_block_bytes  out  8 each  parameters to the SHA3 controller.
- sha3_ready  in  1  SHA3 controller idle, with output available.
- dump_wen  in  1  SHA3 controller dump in progress.

Function
REQ-002 The FSM SHALL have the states IDLE, START, WABS, DUMP, WDUMP, SQZ, WSQZ and FIN.
REQ-003 In IDLE with any req bit set, the block SHALL grant one requester by round-robin.
- Priority goes to the requester not granted last; after reset, bit0 has priority.
- Simultaneous requests SHALL be resolved by this pointer.
REQ-004 At grant, the block SHALL latch that requester's mode, absorb_num, last_bytes and blocks into internal registers.
- shakemode, absorb_num and last_block_bytes SHALL be driven from these latched registers.
- The outputs SHALL be stable from the START cycle until FIN.
REQ-005 START SHALL assert sha3_start for exactly one cycle, then go to WABS.
REQ-006 Each wait state (WABS, WDUMP, WSQZ) SHALL ignore sha3_ready in its first cycle (blanking cycle), then wait for sha3_ready=1.
REQ-007 WABS exit: if latched blocks=0, go to FIN; otherwise go to DUMP.
REQ-008 DUMP SHALL pulse sha3_dumponce for one cycle, then go to WDUMP.
REQ-009 WDUMP SHALL exit once dump_wen=0 and sha3_ready=1 after the blanking cycle.
- On exit it SHALL pulse blk_valid with blk_idx = blocks dumped so far, then increment that count.
- It SHALL then go to FIN if count = latched blocks, otherwise to SQZ.
REQ-010 SQZ SHALL pulse sha3_squeezeonce for one cycle, then go to WSQZ; on sha3_ready=1, WSQZ SHALL return to DUMP.
REQ-011 FIN SHALL pulse done on the granted bit, clear gnt, update the round-robin pointer and return to IDLE.
- The earliest next grant is the following cycle.
REQ-012 Deasserting req during a transaction SHALL be ignored; the transaction completes.
- A req still high after done SHALL be re-arbitrated as a new request.
REQ-013 The block counter SHALL be 16 bits.
- req_blocks = 16'hFFFF SHALL produce 65535 blocks with blk_idx 0 to 65534, without wrap.
REQ-014 Command outputs SHALL be mutually exclusive, and at most one command SHALL be issued per transaction phase.

Reset
REQ-015 rst_n low SHALL asynchronously force:
- FSM to IDLE and round-robin pointer to bit0;
- gnt, done, blk_valid, the command pulses and shakemode to 0;
- blk_idx, absorb_num, last_block_bytes and the counters to 0.
REQ-016 Reset asserted mid-transaction SHALL abandon the transaction with no done pulse; the next grant follows REQ-003.

Configuration
REQ-017 With SHA3_ARB_TIMEOUT_EN defined, the block SHALL include a 10-bit watchdog and an extra output err (1 bit, sticky, cleared only by reset).
- The watchdog counts cycles in WABS, WDUMP and WSQZ, and reloads to 0 on each state entry.
- Reaching 1023 SHALL set err, pulse done on the granted bit and go to IDLE through FIN.
REQ-018 Without SHA3_ARB_TIMEOUT_EN, the block SHALL have no err port and no watchdog logic, and the wait states SHALL wait indefinitely.

Verification
REQ-019 The bench SHALL cover at least these directed scenarios:
- req=01, mode0, absorb_num=1, last_bytes=16, blocks=3 -> gnt=01; sequence start, dump, squeeze, dump, squeeze, dump; blk_idx 0,1,2; one done[0].
- req=11 simultaneously after reset -> requester 0 served first, then requester 1; gnt never two-hot.
- req1 held continuously and req0 pulsed during req1's service -> grants alternate 1,0,1.
- blocks=0 -> sha3_start only, no dump or squeeze, done after sha3_ready.
- rst_n low during WDUMP of block 1 of 4 -> all outputs 0 at once, no done; a fresh req restarts at blk_idx 0.
- With SHA3_ARB_TIMEOUT_EN, sha3_ready tied 0 after start -> err=1 and done pulse 1024 cycles after WABS entry, then IDLE.

Source files
------------

// File: rtl/sha3_arbiter.sv
// Round-robin arbiter that lets the matrix generator and the noise sampler share one SHA3 controller.
// Optional watchdog with a sticky err output: define SHA3_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module sha3_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_mode,
  input  logic [7:0]  req_absorb_num0,
  input  logic [7:0]  req_absorb_num1,
  input  logic [7:0]  req_last_bytes0,
  input  logic [7:0]  req_last_bytes1,
  input  logic [15:0] req_blocks0,
  input  logic [15:0] req_blocks1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        blk_valid,
  output logic [15:0] blk_idx,
  output logic        sha3_start,
  output logic        sha3_squeezeonce,
  output logic        sha3_dumponce,
  output logic        shakemode,
  output logic [7:0]  absorb_num,
  output logic [7:0]  last_block_bytes,
  input  logic        sha3_ready,
  input  logic        dump_wen
`ifdef SHA3_ARB_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [2:0] {IDLE, START, WABS, DUMP, WDUMP, SQZ, WSQZ, FIN} state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        ptr_q, ptr_d;      // 1: requester 1 wins a tie
  logic        mode_q, mode_d;
  logic [7:0]  absn_q, absn_d, lastb_q, lastb_d;
  logic [15:0] blocks_q, blocks_d, cnt_q, cnt_d, idx_q, idx_d;
  logic        vld_q, vld_d;
  logic        blank_q, blank_d;  // high in the first cycle of every state
  logic        wait_st, wait_ok, pick1, tmo;

  assign wait_st = (state_q == WABS) || (state_q == WDUMP) || (state_q == WSQZ);
  assign wait_ok = !blank_q && sha3_ready;
  assign pick1   = req[1] && (!req[0] || ptr_q);

`ifdef SHA3_ARB_TIMEOUT_EN
  logic [9:0] wd_q, wd_d;
  logic       err_q, err_d;

  assign tmo = wait_st && (wd_q == 10'd1023);

  always_comb begin
    wd_d  = (wait_st && state_d == state_q) ? wd_q + 10'd1 : 10'd0;
    err_d = err_q | tmo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ptr_q    <= 1'b0;
      mode_q   <= 1'b0;
      absn_q   <= '0;
      lastb_q  <= '0;
      blocks_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      mode_q   <= mode_d;
      absn_q   <= absn_d;
      lastb_q  <= lastb_d;
      blocks_q <= blocks_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      blank_q  <= blank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (|req) state_d = START;
      START: state_d = WABS;
      WABS:  if (tmo) state_d = FIN;
             else if (wait_ok) state_d = (blocks_q == 16'd0) ? FIN : DUMP;
      DUMP:  state_d = WDUMP;
      WDUMP: if (tmo) state_d = FIN;
             else if (wait_ok && !dump_wen) state_d = ((cnt_q + 16'd1) == blocks_q) ? FIN : SQZ;
      SQZ:   state_d = WSQZ;
      WSQZ:  if (tmo) state_d = FIN;
             else if (wait_ok) state_d = DUMP;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant/latch, block bookkeeping and pointer update
  always_comb begin
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    mode_d   = mode_q;
    absn_d   = absn_q;
    lastb_d  = lastb_q;
    blocks_d = blocks_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    vld_d    = 1'b0;
    blank_d  = (state_d != state_q);
    if (state_q == IDLE && |req) begin
      gnt_d    = pick1 ? 2'b10 : 2'b01;
      mode_d   = pick1 ? req_mode[1]     : req_mode[0];
      absn_d   = pick1 ? req_absorb_num1 : req_absorb_num0;
      lastb_d  = pick1 ? req_last_bytes1 : req_last_bytes0;
      blocks_d = pick1 ? req_blocks1     : req_blocks0;
      cnt_d    = '0;
    end
    if (state_q == WDUMP && state_d != WDUMP && !tmo) begin
      vld_d = 1'b1;
      idx_d = cnt_q;
      cnt_d = cnt_q + 16'd1;
    end
    if (state_q == FIN) begin
      gnt_d = '0;
      ptr_d = gnt_q[0];
    end
  end

  always_comb begin
    sha3_start       = (state_q == START);
    sha3_dumponce    = (state_q == DUMP);
    sha3_squeezeonce = (state_q == SQZ);
    done             = (state_q == FIN) ? gnt_q : 2'b00;
  end

  assign gnt              = gnt_q;
  assign blk_valid        = vld_q;
  assign blk_idx          = idx_q;
  assign shakemode        = mode_q;
  assign absorb_num       = absn_q;
  assign last_block_bytes = lastb_q;

endmodule
